// File: rtl/lc3_pkg.sv
// ---------------------------------------------------------------------------
// lc3_pkg
// Shared types for the LC-3 memory sequencer.
//   memseq_op_t      : command opcodes carried on cmd_op
//   memseq_state_t   : sequencer FSM states
//   memseq_is_write  : true for ops whose final access is a store
//   memseq_is_ind    : true for ops that start with a pointer fetch
// ---------------------------------------------------------------------------
package lc3_pkg;

    typedef enum logic [1:0] {
        MS_READ      = 2'd0,
        MS_WRITE     = 2'd1,
        MS_READ_IND  = 2'd2,
        MS_WRITE_IND = 2'd3
    } memseq_op_t;

    typedef enum logic [1:0] {
        MS_IDLE,
        MS_REQ,
        MS_IND,
        MS_RSP
    } memseq_state_t;

    function automatic logic memseq_is_write(input memseq_op_t op);
        return (op == MS_WRITE) || (op == MS_WRITE_IND);
    endfunction

    function automatic logic memseq_is_ind(input memseq_op_t op);
        return (op == MS_READ_IND) || (op == MS_WRITE_IND);
    endfunction

endpackage

// File: rtl/lc3_memseq_watchdog.sv
// ---------------------------------------------------------------------------
// lc3_memseq_watchdog
// Counts REQ cycles that pass without a memory acknowledge.
// Only instantiated when LC3_MEMSEQ_TIMEOUT_EN is defined.
// Parameters:
//   TIMEOUT_CYC : number of unacknowledged REQ cycles before abort (>= 2)
// Ports:
//   clk      in  clock, rising edge
//   reset    in  synchronous active-high reset, clears the count
//   clear_i  in  restart the count (asserted on each entry to REQ)
//   en_i     in  count this cycle (REQ without mem_ack)
//   tc_o     out terminal count: the current cycle is the TIMEOUT_CYC-th
//                unacknowledged REQ cycle
// ---------------------------------------------------------------------------
module lc3_memseq_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic tc_o
);

    // The count only has to reach TIMEOUT_CYC-1: that value flags the
    // cycle on which the abort happens.
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_o = (cnt_q == TC_VAL);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lc3_mem_sequencer.sv
// ---------------------------------------------------------------------------
// lc3_mem_sequencer
// MAR/MDR command/response memory sequencer for the LC-3 core. Executes
// READ, WRITE, READ_IND (LDI) and WRITE_IND (STI) as a single command
// against variable-latency memory using a req/ack handshake.
//
// Optional feature macro: LC3_MEMSEQ_TIMEOUT_EN
//   defined   : watchdog aborts a REQ after TIMEOUT_CYC cycles without
//               mem_ack and reports rsp_err = 1
//   undefined : REQ waits forever, rsp_err tied low
//
// Parameters:
//   DATA_W      data / MDR width (>= ADDR_W)
//   ADDR_W      address / MAR width
//   TIMEOUT_CYC watchdog terminal count (>= 2), used only with the macro
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_op                memseq_op_t opcode
//   cmd_addr              effective / pointer address
//   cmd_wdata             store data
//   rsp_valid             one-cycle completion pulse
//   rsp_data              MDR contents during rsp_valid
//   rsp_err               timeout abort flag, qualified by rsp_valid
//   mem_req/mem_we        memory request (held until mem_ack) and direction
//   mem_addr/mem_wdata    MAR / MDR driven to memory
//   mem_ack/mem_rdata     memory completion and read data
//   mar/mdr               debug view of MAR / MDR
// ---------------------------------------------------------------------------
module lc3_mem_sequencer
    import lc3_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,

    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic [ADDR_W-1:0] mar,
    output logic [DATA_W-1:0] mdr
);

    if (DATA_W < ADDR_W) begin : g_chk_width
        $error("lc3_mem_sequencer: DATA_W must be >= ADDR_W");
    end
    if (TIMEOUT_CYC < 2) begin : g_chk_timeout
        $error("lc3_mem_sequencer: TIMEOUT_CYC must be >= 2");
    end

    memseq_state_t     state_q, state_d;
    memseq_op_t        op_q,    op_d;
    logic              phase_q, phase_d;
    logic [ADDR_W-1:0] mar_q,   mar_d;
    logic [DATA_W-1:0] mdr_q,   mdr_d;

    memseq_op_t        cmd_op_e;
    logic              access_we;

    assign cmd_op_e = memseq_op_t'(cmd_op);

    // The pointer fetch (phase 1) is always a read; the final access
    // stores only for the write-type ops.
    assign access_we = !phase_q && memseq_is_write(op_q);

`ifdef LC3_MEMSEQ_TIMEOUT_EN
    logic wd_clear;
    logic wd_en;
    logic wd_tc;
    logic err_q, err_d;

    assign wd_clear = ((state_q == MS_IDLE) && cmd_valid) || (state_q == MS_IND);
    assign wd_en    = (state_q == MS_REQ) && !mem_ack;

    lc3_memseq_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear_i(wd_clear),
        .en_i   (wd_en),
        .tc_o   (wd_tc)
    );

    assign rsp_err = (state_q == MS_RSP) && err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        phase_d = phase_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
`ifdef LC3_MEMSEQ_TIMEOUT_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            MS_IDLE: begin
                if (cmd_valid) begin
                    mar_d   = cmd_addr;
                    op_d    = cmd_op_e;
                    phase_d = memseq_is_ind(cmd_op_e);
                    if (memseq_is_write(cmd_op_e)) begin
                        mdr_d = cmd_wdata;
                    end
`ifdef LC3_MEMSEQ_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = MS_REQ;
                end
            end
            MS_REQ: begin
                // An ack on the terminal-count cycle takes priority over the abort.
                if (mem_ack) begin
                    if (phase_q) begin
                        mar_d   = mem_rdata[ADDR_W-1:0];
                        phase_d = 1'b0;
                        state_d = MS_IND;
                    end else begin
                        if (!access_we) begin
                            mdr_d = mem_rdata;
                        end
                        state_d = MS_RSP;
                    end
                end
`ifdef LC3_MEMSEQ_TIMEOUT_EN
                else if (wd_tc) begin
                    err_d   = 1'b1;
                    phase_d = 1'b0;
                    state_d = MS_RSP;
                end
`endif
            end
            MS_IND: begin
                state_d = MS_REQ;
            end
            MS_RSP: begin
                state_d = MS_IDLE;
            end
            default: begin
                state_d = MS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MS_IDLE;
            op_q    <= MS_READ;
            phase_q <= 1'b0;
            mar_q   <= '0;
            mdr_q   <= '0;
`ifdef LC3_MEMSEQ_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            phase_q <= phase_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
`ifdef LC3_MEMSEQ_TIMEOUT_EN
            err_q   <= err_d;
`endif
        end
    end

    // All outputs decode directly from registered state.
    assign cmd_ready = (state_q == MS_IDLE);
    assign mem_req   = (state_q == MS_REQ);
    assign mem_we    = (state_q == MS_REQ) && access_we;
    assign rsp_valid = (state_q == MS_RSP);
    assign rsp_data  = mdr_q;
    assign mem_addr  = mar_q;
    assign mem_wdata = mdr_q;
    assign mar       = mar_q;
    assign mdr       = mdr_q;

endmodule

// File: tb/tb_lc3_mem_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lc3_mem_sequencer
// Self-checking bench for lc3_mem_sequencer: a table of directed commands,
// hand-written multi-cycle sequences, and randomized commands checked against
// a transaction-level memory model. A behavioural memory responder supplies
// mem_ack with configurable latency.
// ---------------------------------------------------------------------------
module tb_lc3_mem_sequencer;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 16;
    localparam int unsigned TO = 8;

    localparam logic [1:0] OP_RD   = 2'd0;
    localparam logic [1:0] OP_WR   = 2'd1;
    localparam logic [1:0] OP_RDI  = 2'd2;
    localparam logic [1:0] OP_WRI  = 2'd3;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] mar;
    logic [DW-1:0] mdr;

    lc3_mem_sequencer #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .mar      (mar),
        .mdr      (mdr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } txn_t;

    txn_t        log_q[$];
    logic [15:0] tbmem  [logic [15:0]];
    logic [15:0] refmem [logic [15:0]];

    // responder controls and bookkeeping
    bit          auto_ack  = 1'b1;
    int          fixed_lat = -1;
    bit          spur_ack  = 1'b0;
    bit          prev_req  = 1'b0;
    bit          prev_ack  = 1'b0;
    int          req_age   = 0;
    int          cur_lat   = 0;
    int          lat_sum   = 0;
    int          req_cycles = 0;
    int          rsp_seen  = 0;
    logic [15:0] req_addr0, req_wd0;
    logic        req_we0;
    logic [15:0] last_rsp_data;
    logic        last_rsp_err;

    function automatic logic [15:0] mem_default(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    function automatic logic [15:0] tb_rd(input logic [15:0] a);
        return tbmem.exists(a) ? tbmem[a] : mem_default(a);
    endfunction

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return refmem.exists(a) ? refmem[a] : mem_default(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: observe outputs 1 time unit after the edge, then act as memory.
    task automatic step();
        @(posedge clk);
        #1;
        if (rsp_valid) begin
            rsp_seen++;
            last_rsp_data = rsp_data;
            last_rsp_err  = rsp_err;
        end
        if (prev_ack) check("req_gap_after_ack", 32'(mem_req), 32'd0);
        mem_ack   = spur_ack;
        mem_rdata = 16'($urandom);
        if (mem_req) begin
            req_cycles++;
            if (!prev_req) begin
                req_age   = 0;
                req_addr0 = mem_addr;
                req_wd0   = mem_wdata;
                req_we0   = mem_we;
                cur_lat   = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
                if (auto_ack) lat_sum += cur_lat;
            end else begin
                req_age++;
                check("mem_addr_stable",  32'(mem_addr),  32'(req_addr0));
                check("mem_wdata_stable", 32'(mem_wdata), 32'(req_wd0));
                check("mem_we_stable",    32'(mem_we),    32'(req_we0));
            end
            if (auto_ack && req_age == cur_lat) begin
                mem_ack = 1'b1;
                if (mem_we) tbmem[mem_addr] = mem_wdata;
                else        mem_rdata = tb_rd(mem_addr);
                log_q.push_back('{we: mem_we, addr: mem_addr, wdata: mem_wdata});
            end
        end
        prev_req = mem_req;
        prev_ack = mem_ack && mem_req;
    endtask

    // Drive one command and wait (bounded) for its response.
    task automatic dut_cmd(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wd,
                           output logic [15:0] got, output logic got_err, output int ncyc);
        log_q.delete();
        lat_sum    = 0;
        rsp_seen   = 0;
        req_cycles = 0;
        check("cmd_ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wd;
        step();
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_addr  = 16'($urandom);
        cmd_wdata = 16'($urandom);
        ncyc = 1;
        while (rsp_seen == 0 && ncyc < 300) begin
            step();
            ncyc++;
        end
        got     = last_rsp_data;
        got_err = last_rsp_err;
        step();
        check("rsp_single_pulse", 32'(rsp_seen), 32'd1);
        check("cmd_ready_after_rsp", 32'(cmd_ready), 32'd1);
    endtask

    // Reference model at transaction level plus DUT run and comparison.
    task automatic run_cmd(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wd,
                           output logic [15:0] got, output int ncyc);
        txn_t        exp_q[$];
        logic [15:0] p;
        logic [15:0] exp_data;
        logic        got_err;
        int          exp_cyc;
        case (op)
            OP_RD: begin
                exp_data = ref_rd(addr);
                exp_q.push_back('{we: 1'b0, addr: addr, wdata: 16'h0});
            end
            OP_WR: begin
                refmem[addr] = wd;
                exp_data = wd;
                exp_q.push_back('{we: 1'b1, addr: addr, wdata: wd});
            end
            OP_RDI: begin
                p = ref_rd(addr);
                exp_data = ref_rd(p);
                exp_q.push_back('{we: 1'b0, addr: addr, wdata: 16'h0});
                exp_q.push_back('{we: 1'b0, addr: p,    wdata: 16'h0});
            end
            default: begin
                p = ref_rd(addr);
                refmem[p] = wd;
                exp_data = wd;
                exp_q.push_back('{we: 1'b0, addr: addr, wdata: 16'h0});
                exp_q.push_back('{we: 1'b1, addr: p,    wdata: wd});
            end
        endcase
        dut_cmd(op, addr, wd, got, got_err, ncyc);
        exp_cyc = ((op == OP_RDI || op == OP_WRI) ? 4 : 2) + lat_sum;
        check("rsp_data_vs_model", 32'(got), 32'(exp_data));
        check("rsp_err_clear", 32'(got_err), 32'd0);
        check("latency", 32'(ncyc), 32'(exp_cyc));
        check("txn_count", 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            check("txn_we",   32'(log_q[i].we),   32'(exp_q[i].we));
            check("txn_addr", 32'(log_q[i].addr), 32'(exp_q[i].addr));
            if (exp_q[i].we) check("txn_wdata", 32'(log_q[i].wdata), 32'(exp_q[i].wdata));
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          lat;
        logic [15:0] exp_data;
        int          exp_cyc;
        int          exp_req;
        int          exp_ntx;
        logic        exp_we_last;
        logic [15:0] exp_addr_last;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #5000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "bench stalled");
    end

    initial begin
        logic [15:0] got;
        logic        gerr;
        int          ncyc;

        vecs[0] = '{OP_RD,  16'h3000, 16'h0000, 0, 16'hBEEF, 2, 1, 1, 1'b0, 16'h3000};
        vecs[1] = '{OP_WR,  16'h4000, 16'h1234, 5, 16'h1234, 7, 6, 1, 1'b1, 16'h4000};
        vecs[2] = '{OP_WRI, 16'h3005, 16'hA5A5, 0, 16'hA5A5, 4, 2, 2, 1'b1, 16'h5000};
        vecs[3] = '{OP_RDI, 16'h3001, 16'h0000, 0, 16'h00FF, 4, 2, 2, 1'b0, 16'h6000};
        vecs[4] = '{OP_RD,  16'h5000, 16'h0000, 1, 16'hA5A5, 3, 2, 1, 1'b0, 16'h5000};
        vecs[5] = '{OP_RDI, 16'h3005, 16'h0000, 2, 16'hA5A5, 8, 6, 2, 1'b0, 16'h5000};
        vecs[6] = '{OP_RD,  16'h4000, 16'h0000, 3, 16'h1234, 5, 4, 1, 1'b0, 16'h4000};

        tbmem[16'h3000] = 16'hBEEF;  refmem[16'h3000] = 16'hBEEF;
        tbmem[16'h3001] = 16'h6000;  refmem[16'h3001] = 16'h6000;
        tbmem[16'h6000] = 16'h00FF;  refmem[16'h6000] = 16'h00FF;
        tbmem[16'h3005] = 16'h5000;  refmem[16'h3005] = 16'h5000;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        repeat (3) step();

        // reset state
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_mem_req",   32'(mem_req),   32'd0);
        check("rst_mem_we",    32'(mem_we),    32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err",   32'(rsp_err),   32'd0);
        check("rst_rsp_data",  32'(rsp_data),  32'd0);
        check("rst_mar",       32'(mar),       32'd0);
        check("rst_mdr",       32'(mdr),       32'd0);
        reset = 1'b0;
        step();
        check("post_rst_idle", 32'(cmd_ready), 32'd1);

        // directed table
        for (int v = 0; v < 7; v++) begin
            fixed_lat = vecs[v].lat;
            run_cmd(vecs[v].op, vecs[v].addr, vecs[v].wdata, got, ncyc);
            check($sformatf("vec%0d_data", v), 32'(got), 32'(vecs[v].exp_data));
            check($sformatf("vec%0d_cycles", v), 32'(ncyc), 32'(vecs[v].exp_cyc));
            check($sformatf("vec%0d_req_cycles", v), 32'(req_cycles), 32'(vecs[v].exp_req));
            check($sformatf("vec%0d_ntx", v), 32'(log_q.size()), 32'(vecs[v].exp_ntx));
            if (log_q.size() > 0) begin
                check($sformatf("vec%0d_first_addr", v), 32'(log_q[0].addr), 32'(vecs[v].addr));
                check($sformatf("vec%0d_last_we", v), 32'(log_q[log_q.size()-1].we), 32'(vecs[v].exp_we_last));
                check($sformatf("vec%0d_last_addr", v), 32'(log_q[log_q.size()-1].addr), 32'(vecs[v].exp_addr_last));
            end
        end

        // mem_ack while idle must be ignored (last command was READ 0x4000 -> 0x1234)
        spur_ack = 1'b1;
        repeat (3) step();
        spur_ack = 1'b0;
        step();
        check("spur_ack_mdr", 32'(mdr), 32'h1234);
        check("spur_ack_mar", 32'(mar), 32'h4000);
        check("spur_ack_idle", 32'(cmd_ready), 32'd1);
        check("spur_ack_no_rsp", 32'(rsp_valid), 32'd0);

        // READ_IND with cmd_valid held throughout: no re-accept until IDLE
        log_q.delete();
        rsp_seen  = 0;
        fixed_lat = 0;
        cmd_valid = 1'b1;
        cmd_op    = OP_RDI;
        cmd_addr  = 16'h3001;
        cmd_wdata = 16'h0000;
        step();
        repeat (3) begin
            check("held_cmd_ready_busy", 32'(cmd_ready), 32'd0);
            step();
        end
        check("held_cmd_ready_rsp", 32'(cmd_ready), 32'd0);
        check("held_rsp_valid", 32'(rsp_valid), 32'd1);
        check("held_rsp_data", 32'(rsp_data), 32'h00FF);
        step();
        check("held_back_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b0;
        step();
        step();
        check("held_no_second_accept", 32'(log_q.size()), 32'd2);
        check("held_single_rsp", 32'(rsp_seen), 32'd1);
        check("held_mem_req_low", 32'(mem_req), 32'd0);

        // reset in the middle of a READ with no ack
        auto_ack  = 1'b0;
        rsp_seen  = 0;
        cmd_valid = 1'b1;
        cmd_op    = OP_RD;
        cmd_addr  = 16'h3000;
        step();
        cmd_valid = 1'b0;
        step();
        check("midrst_req_before", 32'(mem_req), 32'd1);
        reset = 1'b1;
        step();
        check("midrst_mem_req",   32'(mem_req),   32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_mar",       32'(mar),       32'd0);
        check("midrst_mdr",       32'(mdr),       32'd0);
        check("midrst_mem_we",    32'(mem_we),    32'd0);
        reset    = 1'b0;
        auto_ack = 1'b1;
        repeat (4) step();
        check("midrst_no_rsp", 32'(rsp_seen), 32'd0);
        check("midrst_still_idle", 32'(mem_req), 32'd0);

`ifdef LC3_MEMSEQ_TIMEOUT_EN
        // watchdog abort: no ack at all (mdr is 0 after the reset above)
        auto_ack = 1'b0;
        dut_cmd(OP_RD, 16'h3000, 16'h0000, got, gerr, ncyc);
        check("to_rd_err", 32'(gerr), 32'd1);
        check("to_rd_req_cycles", 32'(req_cycles), 32'(TO));
        check("to_rd_cycles", 32'(ncyc), 32'(TO + 1));
        check("to_rd_mdr_kept", 32'(got), 32'h0000);
        // ack on the terminal-count cycle completes normally
        auto_ack  = 1'b1;
        fixed_lat = TO - 1;
        run_cmd(OP_RD, 16'h3000, 16'h0000, got, ncyc);
        check("to_ack_last_data", 32'(got), 32'hBEEF);
        // WRITE_IND timing out on the pointer fetch skips the store
        auto_ack = 1'b0;
        dut_cmd(OP_WRI, 16'h3005, 16'h1111, got, gerr, ncyc);
        check("to_wri_err", 32'(gerr), 32'd1);
        check("to_wri_req_cycles", 32'(req_cycles), 32'(TO));
        check("to_wri_no_txn", 32'(log_q.size()), 32'd0);
        check("to_wri_rsp_data", 32'(got), 32'h1111);
        auto_ack = 1'b1;
`endif

        // randomized commands against the reference model
        fixed_lat = -1;
        for (int n = 0; n < 80; n++) begin
            logic [1:0]  rop;
            logic [15:0] raddr;
            logic [15:0] rwd;
            rop   = 2'($urandom);
            raddr = ($urandom_range(0, 3) == 0) ? 16'($urandom) : (16'h7000 + 16'($urandom_range(0, 7)));
            rwd   = 16'($urandom);
            run_cmd(rop, raddr, rwd, got, ncyc);
            repeat ($urandom_range(0, 2)) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
